store_buffer: RTL
=================

Name: store_buffer

Overview:
- Sits beside load_unit in the LSU and directly feeds it: produces the load-wait signal consumed as load_wait_i, and drains stores to the data cache/system bus.
- Translated stores enter as speculative entries. The commit stage promotes them to committed in program order. Committed entries drain in order to memory.
- Every live entry is checked against the pending load's physical address, so loads never pass an overlapping older store.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2
PADDR_W, 56, physical address width
DATA_W, 64, store data width; byte lanes are DATA_W/8 = 8

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  discard all speculative entries
store_valid_i  in  1  store request valid
store_ready_o  out  1  buffer can accept a store
store_paddr_i  in  PADDR_W  store physical address (naturally aligned, guaranteed upstream)
store_size_i  in  2  0=1B, 1=2B, 2=4B, 3=8B
store_data_i  in  DATA_W  store data, LSB-aligned
commit_i  in  1  promote oldest speculative entry to committed
commit_ready_o  out  1  at least one speculative entry exists
load_addr_i  in  PADDR_W  physical address of the buffered load
load_wait_o  out  1  load overlaps a live store
d_store_req_o  out  1  drain request for head entry
d_store_addr_o  out  PADDR_W  head address, bits [2:0] forced to 0
d_store_data_o  out  DATA_W  lane-shifted data
d_store_be_o  out  8  byte enables
d_store_ack_i  in  1  drain complete
d_store_err_i  in  1  bus error, qualified by ack
store_err_o  out  1  one-cycle pulse on errored ack
store_err_addr_o  out  PADDR_W  full paddr of the errored store
empty_o  out  1  no live entries (fence support)

Behaviour:
- Storage is a circular array with three pointers:
  - head: oldest committed entry.
  - cmt: oldest speculative entry.
  - tail: next free slot.
- Counters com_cnt and spec_cnt, each 0..DEPTH; their sum never exceeds DEPTH.
- Reset: all pointers and counters 0. Every output is 0 except empty_o=1 and store_ready_o=1.
- store_ready_o = (com_cnt+spec_cnt < DEPTH) & ~flush_i.
- Accept on store_valid_i & store_ready_o: write the entry at tail, tail+1, spec_cnt+1. The entry is visible to load_wait_o from the next cycle.
- commit_ready_o = (spec_cnt != 0).
  - commit_i & commit_ready_o: cmt+1, spec_cnt-1, com_cnt+1.
  - commit_i with spec_cnt==0 is ignored.
  - An entry accepted in the same cycle is never committed by that cycle's commit_i.
- Drain:
  - d_store_req_o = (com_cnt != 0). Address, data and byte enables come from the head entry and stay stable until ack.
  - On d_store_ack_i: head+1, com_cnt-1.
  - If d_store_err_i is also set: store_err_o pulses 1 in the next cycle and store_err_addr_o is registered. The entry is removed either way.
  - An ack while com_cnt==0 is ignored.
- Lane formatting:
  - d_store_be_o = base_mask << paddr[2:0], where base_mask = 0x01/0x03/0x0F/0xFF for size 0/1/2/3.
  - d_store_data_o = data << (8*paddr[2:0]).
- Flush: tail <= cmt and spec_cnt <= 0 at the next edge; committed entries are kept and keep draining. Flush has priority over accept and commit in the same cycle. A concurrent drain ack is still honoured.
- Simultaneous accept, commit and ack in one cycle: all three apply; the counters update by their net deltas.
- load_wait_o is combinational: 1 if any live entry (speculative or committed) has paddr[PADDR_W-1:3] == load_addr_i[PADDR_W-1:3]. Overlap is conservative, at 8-byte granularity. The head entry still counts while its ack is pending.
- empty_o = (com_cnt==0) & (spec_cnt==0).
- Pointer wrap: pointers are modulo DEPTH, and full/empty are derived from the counters.
- Asynchronous reset mid-drain drops everything; d_store_req_o falls immediately.

Test Plan:
- Accept 8 stores with no commit -> store_ready_o=0 after the 8th. A 9th store_valid_i is not accepted; spec_cnt=8 and d_store_req_o=0.
- Store {paddr=0x1004, size=1, data=0xBEEF}, then commit, then hold ack low 3 cycles -> d_store_addr_o=0x1000, d_store_be_o=0x30, d_store_data_o=0x0000BEEF00000000. The request holds stable, then clears on ack; empty_o=1 after.
- Stores to 0x2000 and 0x3008 live, load_addr_i=0x2006 -> load_wait_o=1. Change to 0x2010 -> 0. Drain 0x2000, then load_addr_i=0x2006 -> 0.
- 3 stores, commit 1, assert flush_i together with store_valid_i -> the new store is rejected and spec_cnt=0. The committed entry still drains; after its ack empty_o=1.
- Single cycle with commit_i, store accept and drain ack -> counters net-correct: com_cnt unchanged and spec_cnt unchanged. Continuous traffic of 20 stores exercises pointer wrap; drained order matches input order.
- Committed store 0x4000 acked with d_store_err_i=1 -> store_err_o=1 for exactly one cycle, store_err_addr_o=0x4000, entry removed.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer port bundle: LSU-side store/commit/load-check signals and the drain bus.
interface store_buffer_if #(
  parameter int PADDR_W = 56,
  parameter int DATA_W  = 64
);
  logic               flush_i;
  logic               store_valid_i;
  logic               store_ready_o;
  logic [PADDR_W-1:0] store_paddr_i;
  logic [1:0]         store_size_i;
  logic [DATA_W-1:0]  store_data_i;
  logic               commit_i;
  logic               commit_ready_o;
  logic [PADDR_W-1:0] load_addr_i;
  logic               load_wait_o;
  logic               d_store_req_o;
  logic [PADDR_W-1:0] d_store_addr_o;
  logic [DATA_W-1:0]  d_store_data_o;
  logic [7:0]         d_store_be_o;
  logic               d_store_ack_i;
  logic               d_store_err_i;
  logic               store_err_o;
  logic [PADDR_W-1:0] store_err_addr_o;
  logic               empty_o;

  modport slave (
    input  flush_i, store_valid_i, store_paddr_i, store_size_i, store_data_i,
           commit_i, load_addr_i, d_store_ack_i, d_store_err_i,
    output store_ready_o, commit_ready_o, load_wait_o, d_store_req_o,
           d_store_addr_o, d_store_data_o, d_store_be_o, store_err_o,
           store_err_addr_o, empty_o
  );

  modport master (
    output flush_i, store_valid_i, store_paddr_i, store_size_i, store_data_i,
           commit_i, load_addr_i, d_store_ack_i, d_store_err_i,
    input  store_ready_o, commit_ready_o, load_wait_o, d_store_req_o,
           d_store_addr_o, d_store_data_o, d_store_be_o, store_err_o,
           store_err_addr_o, empty_o
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: speculative stores are committed in order, drained in order, and
// checked against the pending load address so loads never pass an older store.
module store_buffer #(
  parameter int DEPTH   = 8,
  parameter int PADDR_W = 56,
  parameter int DATA_W  = 64
) (
  input logic           clk_i,
  input logic           rst_ni,
  store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PADDR_W-1:0] addr_mem [DEPTH];
  logic [1:0]         size_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] cmt;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] com_cnt;
  logic [CNT_W-1:0] spec_cnt;
  logic [CNT_W-1:0] used;

  logic accept;
  logic do_commit;
  logic do_drain;

  logic [PADDR_W-1:0] head_addr;
  logic [2:0]         head_off;
  logic [7:0]         base_mask;
  logic               load_hit;
  logic [PTR_W-1:0]   rel;
  logic               unused_load_bits;

  assign used = com_cnt + spec_cnt;

  assign sb.store_ready_o  = (used < CNT_W'(DEPTH)) & ~sb.flush_i;
  assign sb.commit_ready_o = (spec_cnt != '0);
  assign sb.empty_o        = (com_cnt == '0) & (spec_cnt == '0);

  // Flush squashes a same-cycle commit; a drain ack is always honoured.
  assign accept    = sb.store_valid_i & sb.store_ready_o;
  assign do_commit = sb.commit_i & (spec_cnt != '0) & ~sb.flush_i;
  assign do_drain  = sb.d_store_ack_i & (com_cnt != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head     <= '0;
      cmt      <= '0;
      tail     <= '0;
      com_cnt  <= '0;
      spec_cnt <= '0;
    end else begin
      if (do_drain) begin
        head <= head + PTR_W'(1);
      end
      com_cnt <= com_cnt + CNT_W'(do_commit) - CNT_W'(do_drain);
      if (sb.flush_i) begin
        tail     <= cmt;
        spec_cnt <= '0;
      end else begin
        if (accept) begin
          tail <= tail + PTR_W'(1);
        end
        if (do_commit) begin
          cmt <= cmt + PTR_W'(1);
        end
        spec_cnt <= spec_cnt + CNT_W'(accept) - CNT_W'(do_commit);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_mem[tail] <= sb.store_paddr_i;
      size_mem[tail] <= sb.store_size_i;
      data_mem[tail] <= sb.store_data_i;
    end
  end

  always_comb begin
    head_addr = addr_mem[head];
    head_off  = head_addr[2:0];
    base_mask = 8'h00;
    case (size_mem[head])
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  // Drain outputs are zeroed while nothing is committed so stale slots never show.
  assign sb.d_store_req_o  = (com_cnt != '0);
  assign sb.d_store_addr_o = sb.d_store_req_o ? {head_addr[PADDR_W-1:3], 3'b000} : '0;
  assign sb.d_store_be_o   = sb.d_store_req_o ? (base_mask << head_off) : '0;
  assign sb.d_store_data_o = sb.d_store_req_o ? (data_mem[head] << {head_off, 3'b000}) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb.store_err_o      <= 1'b0;
      sb.store_err_addr_o <= '0;
    end else begin
      sb.store_err_o <= do_drain & sb.d_store_err_i;
      if (do_drain & sb.d_store_err_i) begin
        sb.store_err_addr_o <= head_addr;
      end
    end
  end

  // A slot is live when its distance from head is below the total occupancy.
  always_comb begin
    load_hit = 1'b0;
    rel      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head;
      if ((CNT_W'(rel) < used) &&
          (addr_mem[i][PADDR_W-1:3] == sb.load_addr_i[PADDR_W-1:3])) begin
        load_hit = 1'b1;
      end
    end
  end

  assign sb.load_wait_o = load_hit;

  assign unused_load_bits = ^sb.load_addr_i[2:0];
endmodule
